// File: rtl/vga_write_arbiter_if.sv
// vga_write_arbiter_if: bundles the drawing-engine side and the VGA-adapter
// side of the pixel-write arbiter.
//   master : drawing engines / test driver (drive req, wr_in, x_in, y_in,
//            color_in; observe gnt, VGA_*, busy, collision)
//   slave  : the arbiter itself
//   req      [NUM_REQ]     burst request per engine (level)
//   wr_in    [NUM_REQ]     pixel write strobe per engine
//   x_in     [10*NUM_REQ]  packed x, engine i at [10i+9:10i]
//   y_in     [9*NUM_REQ]   packed y
//   color_in [9*NUM_REQ]   packed RGB333
//   gnt      [NUM_REQ]     one-hot registered grant
//   VGA_x/VGA_y/VGA_color/VGA_write  forwarded pixel write
//   busy       arbiter not idle
//   collision  sticky: a write was attempted without a grant
interface vga_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    wr_in;
    logic [10*NUM_REQ-1:0] x_in;
    logic [9*NUM_REQ-1:0]  y_in;
    logic [9*NUM_REQ-1:0]  color_in;
    logic [NUM_REQ-1:0]    gnt;
    logic [9:0]            VGA_x;
    logic [8:0]            VGA_y;
    logic [8:0]            VGA_color;
    logic                  VGA_write;
    logic                  busy;
    logic                  collision;

    modport master (
        output req, wr_in, x_in, y_in, color_in,
        input  gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy, collision
    );

    modport slave (
        input  req, wr_in, x_in, y_in, color_in,
        output gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy, collision
    );
endinterface

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin owner of the single VGA pixel-write port.
// One engine at a time holds the grant for its whole burst; only its writes
// are forwarded, with one cycle of register latency. Each handover costs a
// GAP cycle plus an IDLE arbitration cycle. With MAX_HOLD != 0 a grant is
// forcibly released after MAX_HOLD cycles if another engine is waiting.
// Ports:
//   Clock   system clock
//   Resetn  asynchronous active-low reset
//   bus     vga_write_arbiter_if.slave (requests, pixel inputs, grant,
//           forwarded VGA write, busy, collision)
module vga_write_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    vga_write_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StGranted, StGap} state_e;

    // Counter only needs to reach MAX_HOLD-1; it saturates at all-ones.
    localparam int unsigned    HOLD_W    = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD) - HOLD_W'(1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [9:0]           vga_x_q, vga_x_d;
    logic [8:0]           vga_y_q, vga_y_d;
    logic [8:0]           vga_color_q, vga_color_d;
    logic                 vga_write_q, vga_write_d;
    logic                 collision_q, collision_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [9:0]           x_sel;
    logic [8:0]           y_sel;
    logic [8:0]           color_sel;
    logic                 wr_sel;
    logic                 req_sel;
    logic                 others_pending;
    logic                 release_now;

    // Round-robin pick: first requester at or above rr_ptr, else wrap to
    // the lowest requester below it.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!sel_found && i >= int'(rr_ptr_q) && bus.req[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!sel_found && i < int'(rr_ptr_q) && bus.req[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Slice mux for the current owner.
    always_comb begin
        x_sel     = '0;
        y_sel     = '0;
        color_sel = '0;
        wr_sel    = 1'b0;
        req_sel   = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gidx_q == IDX_W'(i)) begin
                x_sel     = bus.x_in[10*i +: 10];
                y_sel     = bus.y_in[9*i +: 9];
                color_sel = bus.color_in[9*i +: 9];
                wr_sel    = bus.wr_in[i];
                req_sel   = bus.req[i];
            end
        end
    end

    // gnt_q is one-hot on the owner while granted, so masking it leaves
    // exactly the competing requests.
    assign others_pending = |(bus.req & ~gnt_q);
    assign release_now    = !req_sel ||
                            ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_pending);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        vga_write_d = 1'b0;
        collision_d = collision_q | (|(bus.wr_in & ~gnt_q));

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    gidx_d  = sel_idx;
                    hold_d  = '0;
                    state_d = StGranted;
                end
            end
            StGranted: begin
                vga_x_d     = x_sel;
                vga_y_d     = y_sel;
                vga_color_d = color_sel;
                vga_write_d = wr_sel;
                if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (release_now) begin
                    gnt_d    = '0;
                    rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    state_d  = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_write_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            vga_write_q <= vga_write_d;
            collision_q <= collision_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.VGA_x     = vga_x_q;
    assign bus.VGA_y     = vga_y_q;
    assign bus.VGA_color = vga_color_q;
    assign bus.VGA_write = vga_write_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.collision = collision_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the arbiter (owner,
// pointer, gap flag, hold age) kept in plain integers.
module tb_vga_write_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;

    vga_write_arbiter_if #(.NUM_REQ(N)) bus ();

    vga_write_arbiter #(
        .NUM_REQ  (N),
        .IDX_W    (2),
        .MAX_HOLD (MH)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Model state: owner -1 means nobody holds the port.
    int         m_owner;
    bit         m_gap;
    int         m_ptr;
    int         m_hold;
    logic [3:0] m_gnt;
    logic [9:0] m_vx;
    logic [8:0] m_vy;
    logic [8:0] m_vc;
    logic       m_vw;
    logic       m_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_gnt = '0;
        m_vx = '0; m_vy = '0; m_vc = '0; m_vw = 1'b0; m_col = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] rq;
        logic [3:0] wr;
        int g;
        bit rel;
        rq = bus.req;
        wr = bus.wr_in;
        if ((wr & ~m_gnt) != 4'b0) m_col = 1'b1;
        if (m_gap) begin
            m_gap = 0;
            m_vw  = 1'b0;
        end else if (m_owner < 0) begin
            m_vw = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && rq[c]) begin
                    m_owner = c;
                    m_gnt   = 4'b0001 << c;
                    m_hold  = 0;
                end
            end
        end else begin
            g    = m_owner;
            m_vx = bus.x_in[10*g +: 10];
            m_vy = bus.y_in[9*g +: 9];
            m_vc = bus.color_in[9*g +: 9];
            m_vw = wr[g];
            rel  = !rq[g] || (MH != 0 && m_hold == MH - 1 && (rq & ~(4'b0001 << g)) != 4'b0);
            if (m_hold < 1000) m_hold++;
            if (rel) begin
                m_gnt   = '0;
                m_ptr   = (g + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gnt"},       32'(bus.gnt),       32'(m_gnt));
        check({tag, ".write"},     32'(bus.VGA_write), 32'(m_vw));
        check({tag, ".x"},         32'(bus.VGA_x),     32'(m_vx));
        check({tag, ".y"},         32'(bus.VGA_y),     32'(m_vy));
        check({tag, ".color"},     32'(bus.VGA_color), 32'(m_vc));
        check({tag, ".busy"},      32'(bus.busy),      32'((m_owner >= 0) || m_gap));
        check({tag, ".collision"}, 32'(bus.collision), 32'(m_col));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge Clock);
        #1;
        compare_all(tag);
    endtask

    task automatic set_px(input int i, input int x, input int y, input int c);
        bus.x_in[10*i +: 10]    = 10'(x);
        bus.y_in[9*i +: 9]      = 9'(y);
        bus.color_in[9*i +: 9]  = 9'(c);
    endtask

    task automatic clear_inputs();
        bus.req = '0; bus.wr_in = '0; bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;
    endtask

    // Called just after a clock edge; pulses reset between edges.
    task automatic apply_reset();
        clear_inputs();
        #1 Resetn = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        Resetn = 1'b1;
    endtask

    initial begin
        int cnt;
        int guard;
        bit raised;
        model_reset();
        clear_inputs();

        // 1. Reset with random inputs, no clock edge yet.
        #1;
        bus.req = 4'($urandom); bus.wr_in = 4'($urandom);
        bus.x_in = 40'({$urandom, $urandom}); bus.y_in = 36'({$urandom, $urandom});
        bus.color_in = 36'({$urandom, $urandom});
        Resetn = 1'b0;
        #2;
        compare_all("t1_async");
        check("t1_gnt_zero", 32'(bus.gnt), 32'd0);
        clear_inputs();
        Resetn = 1'b1;
        tick("t1_idle0");
        tick("t1_idle1");
        check("t1_busy", 32'(bus.busy), 32'd0);

        // 2. Single requester, 3 forwarded writes.
        bus.req[0] = 1'b1;
        tick("t2_grant");
        check("t2_gnt", 32'(bus.gnt), 32'h1);
        bus.wr_in[0] = 1'b1;
        set_px(0, 120, 200, 9'h1C0);
        tick("t2_w0");
        check("t2_w0_x", 32'(bus.VGA_x), 32'd120);
        check("t2_w0_c", 32'(bus.VGA_color), 32'h1C0);
        set_px(0, 121, 200, 9'h000);
        tick("t2_w1");
        check("t2_w1_x", 32'(bus.VGA_x), 32'd121);
        check("t2_w1_c", 32'(bus.VGA_color), 32'h000);
        set_px(0, 122, 200, 9'h1C0);
        tick("t2_w2");
        check("t2_w2_x", 32'(bus.VGA_x), 32'd122);
        check("t2_w2_wr", 32'(bus.VGA_write), 32'd1);
        bus.wr_in[0] = 1'b0;
        bus.req[0] = 1'b0;
        tick("t2_rel");
        tick("t2_gap");
        tick("t2_idle");

        // 3. Round-robin from pointer 0.
        apply_reset();
        bus.req[1] = 1'b1; bus.req[2] = 1'b1;
        tick("t3_g1");
        check("t3_gnt1", 32'(bus.gnt), 32'h2);
        for (int k = 0; k < 4; k++) tick("t3_hold");
        bus.req[1] = 1'b0;
        tick("t3_rel");
        check("t3_gap_gnt", 32'(bus.gnt), 32'h0);
        tick("t3_idle");
        check("t3_idle_gnt", 32'(bus.gnt), 32'h0);
        tick("t3_g2");
        check("t3_gnt2", 32'(bus.gnt), 32'h4);
        bus.req[2] = 1'b0;
        tick("t3_rel2");
        tick("t3_gap2");
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        tick("t3_g0");
        check("t3_gnt0_wrap", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        for (int k = 0; k < 3; k++) tick("t3_drain");

        // 4. Hold limit preempts a continuous requester.
        apply_reset();
        bus.req[0] = 1'b1;
        tick("t4_g0");
        cnt = (bus.gnt == 4'h1) ? 1 : 0;
        raised = 0;
        guard = 0;
        while (bus.gnt == 4'h1 && guard < 20) begin
            if (cnt == 2 && !raised) begin
                bus.req[3] = 1'b1;
                raised = 1;
            end
            tick("t4_hold");
            if (bus.gnt == 4'h1) cnt++;
            guard++;
        end
        check("t4_hold_len", 32'(cnt), 32'd8);
        tick("t4_idle");
        check("t4_idle_gnt", 32'(bus.gnt), 32'h0);
        tick("t4_g3");
        check("t4_gnt3", 32'(bus.gnt), 32'h8);
        tick("t4_h3a");
        tick("t4_h3b");
        bus.req[3] = 1'b0;
        tick("t4_rel3");
        tick("t4_gap3");
        tick("t4_back0");
        check("t4_gnt0_back", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        for (int k = 0; k < 3; k++) tick("t4_drain");

        // Randomized clean traffic: writes only from the current owner.
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
                set_px(i, int'($urandom_range(1023)), int'($urandom_range(511)),
                       int'($urandom_range(511)));
            end
            bus.wr_in = 4'($urandom) & m_gnt;
            tick("rnd_clean");
        end
        check("rnd_clean_nocol", 32'(bus.collision), 32'd0);

        // 5. Write without a grant is blocked and flagged.
        apply_reset();
        bus.req[0] = 1'b1;
        tick("t5_g0");
        bus.wr_in[0] = 1'b1; set_px(0, 10, 20, 30);
        tick("t5_w0");
        bus.wr_in[2] = 1'b1; set_px(2, 500, 5, 5); set_px(0, 11, 20, 30);
        tick("t5_intr");
        check("t5_x_not500", 32'(bus.VGA_x), 32'd11);
        check("t5_col", 32'(bus.collision), 32'd1);
        bus.wr_in = '0;
        bus.req = '0;
        tick("t5_rel");
        tick("t5_gap");
        bus.req[1] = 1'b1;
        tick("t5_g1");
        bus.wr_in[1] = 1'b1; set_px(1, 7, 8, 9);
        tick("t5_w1");
        check("t5_col_sticky", 32'(bus.collision), 32'd1);

        // 6. Reset mid-burst, then re-grant.
        tick("t6_w1");
        check("t6_pre_wr", 32'(bus.VGA_write), 32'd1);
        #1 Resetn = 1'b0;
        model_reset();
        #1;
        check("t6_gnt_async", 32'(bus.gnt), 32'h0);
        check("t6_wr_async", 32'(bus.VGA_write), 32'd0);
        check("t6_col_async", 32'(bus.collision), 32'd0);
        bus.wr_in = '0;
        #1 Resetn = 1'b1;
        tick("t6_regrant");
        check("t6_gnt1", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        for (int k = 0; k < 3; k++) tick("t6_drain");

        // Fully random traffic including unauthorised writes.
        for (int c = 0; c < 200; c++) begin
            bus.req   = 4'($urandom);
            bus.wr_in = 4'($urandom);
            bus.x_in  = 40'({$urandom, $urandom});
            bus.y_in  = 36'({$urandom, $urandom});
            bus.color_in = 36'({$urandom, $urandom});
            tick("rnd_dirty");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
